// File: rtl/ysyx_22040237_idu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ysyx_22040237_idu_pkg : shared constants and types for the IDU      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package ysyx_22040237_idu_pkg;

  localparam logic [7:0] ysyx_22040237_INST_NOP = 8'h00;
  localparam logic [7:0] ysyx_22040237_INST_ADD = 8'h01;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [31:0] EBREAK_ENC = 32'h00100073;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } idu_state_e;

endpackage
`default_nettype wire

// File: rtl/ysyx_22040237_imm_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ysyx_22040237_imm_gen : I/U/J immediate extraction, sign-extended   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ysyx_22040237_imm_gen
  import ysyx_22040237_idu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm
);

  // rd field carries no immediate bits for the formats handled here
  logic unused_rd;
  assign unused_rd = ^inst[11:7];

  always_comb begin
    imm = '0;
    case (inst[6:0])
      OPC_OP_IMM, OPC_JALR: imm = {{(XLEN-12){inst[31]}}, inst[31:20]};
      OPC_LUI, OPC_AUIPC:   imm = {{(XLEN-32){inst[31]}}, inst[31:12], 12'b0};
      OPC_JAL:              imm = {{(XLEN-21){inst[31]}}, inst[31], inst[19:12],
                                   inst[20], inst[30:21], 1'b0};
      default:              imm = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ysyx_22040237_idu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ysyx_22040237_idu : decode stage with single-entry output register  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ysyx_22040237_idu
  import ysyx_22040237_idu_pkg::*;
#(
  parameter int          XLEN        = 64,
  parameter logic [31:0] EBREAK_INST = EBREAK_ENC
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [31:0]     if_inst,
  input  logic [XLEN-1:0] if_pc,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [7:0]      inst_opcode,
  output logic [XLEN-1:0] op1,
  output logic [XLEN-1:0] op2,
  output logic [XLEN-1:0] op1_jump,
  output logic [XLEN-1:0] op2_jump,
  output logic [4:0]      rd_addr,
  output logic            rd_wen,
  output logic            inst_ebreak,
  output logic            invalid_inst,
  output logic            halted
);

  idu_state_e      state;
  logic            ebreak_q;
  logic            invalid_q;
  logic            accept;
  logic [XLEN-1:0] imm;

  logic            dec_ok;
  logic            d_ebreak;
  logic            d_invalid;
  logic [7:0]      d_opcode;
  logic [XLEN-1:0] d_op1, d_op2, d_op1_jump, d_op2_jump;
  logic [4:0]      d_rd;
  logic            d_wen;

  assign rs1_addr = if_inst[19:15];
  assign rs2_addr = if_inst[24:20];

  assign if_ready = (state == ST_RUN) && (!ex_valid || ex_ready);
  assign accept   = if_valid && if_ready;

  assign halted       = (state == ST_HALT);
  assign inst_ebreak  = ebreak_q && ex_valid;
  assign invalid_inst = invalid_q && ex_valid;

  ysyx_22040237_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .inst (if_inst),
    .imm  (imm)
  );

  always_comb begin
    dec_ok     = 1'b0;
    d_ebreak   = 1'b0;
    d_invalid  = 1'b0;
    d_opcode   = ysyx_22040237_INST_NOP;
    d_op1      = '0;
    d_op2      = '0;
    d_op1_jump = '0;
    d_op2_jump = '0;
    d_rd       = 5'd0;
    d_wen      = 1'b0;

    case (if_inst[6:0])
      OPC_OP_IMM: if (if_inst[14:12] == 3'b000) begin
        dec_ok = 1'b1;
        d_op1  = rs1_data;
        d_op2  = imm;
      end
      OPC_OP: if (if_inst[14:12] == 3'b000 && if_inst[31:25] == 7'd0) begin
        dec_ok = 1'b1;
        d_op1  = rs1_data;
        d_op2  = rs2_data;
      end
      OPC_LUI: begin
        dec_ok = 1'b1;
        d_op2  = imm;
      end
      OPC_AUIPC: begin
        dec_ok = 1'b1;
        d_op1  = if_pc;
        d_op2  = imm;
      end
      // link value in op1/op2, target expressed as op1_jump - op2_jump
      OPC_JAL: begin
        dec_ok     = 1'b1;
        d_op1      = if_pc;
        d_op2      = XLEN'(4);
        d_op1_jump = if_pc;
        d_op2_jump = '0 - imm;
      end
      OPC_JALR: if (if_inst[14:12] == 3'b000) begin
        dec_ok     = 1'b1;
        d_op1      = if_pc;
        d_op2      = XLEN'(4);
        d_op1_jump = rs1_data;
        d_op2_jump = '0 - imm;
      end
      default: dec_ok = 1'b0;
    endcase

    if (if_inst == EBREAK_INST || !dec_ok) begin
      d_ebreak   = (if_inst == EBREAK_INST);
      d_invalid  = (if_inst != EBREAK_INST);
      d_op1      = '0;
      d_op2      = '0;
      d_op1_jump = '0;
      d_op2_jump = '0;
    end else begin
      d_opcode = ysyx_22040237_INST_ADD;
      d_rd     = if_inst[11:7];
      d_wen    = (if_inst[11:7] != 5'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_RUN;
      ex_valid    <= 1'b0;
      ebreak_q    <= 1'b0;
      invalid_q   <= 1'b0;
      inst_opcode <= ysyx_22040237_INST_NOP;
      op1         <= '0;
      op2         <= '0;
      op1_jump    <= '0;
      op2_jump    <= '0;
      rd_addr     <= 5'd0;
      rd_wen      <= 1'b0;
    end else if (accept) begin
      ex_valid    <= 1'b1;
      ebreak_q    <= d_ebreak;
      invalid_q   <= d_invalid;
      inst_opcode <= d_opcode;
      op1         <= d_op1;
      op2         <= d_op2;
      op1_jump    <= d_op1_jump;
      op2_jump    <= d_op2_jump;
      rd_addr     <= d_rd;
      rd_wen      <= d_wen;
      if (d_ebreak || d_invalid) begin
        state <= ST_HALT;
      end
    end else if (ex_valid && ex_ready) begin
      ex_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22040237_idu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ysyx_22040237_idu : self-checking bench with reference decoder   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_ysyx_22040237_idu;

  localparam logic [7:0] NOP = 8'h00;
  localparam logic [7:0] ADD = 8'h01;

  typedef struct packed {
    logic [7:0]  opc;
    logic [63:0] op1, op2, j1, j2;
    logic [4:0]  rd;
    logic        wen, ebreak, invalid;
  } dec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid, if_ready, ex_valid, ex_ready;
  logic [31:0] if_inst;
  logic [63:0] if_pc, rs1_data, rs2_data;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic [7:0]  inst_opcode;
  logic [63:0] op1, op2, op1_jump, op2_jump;
  logic        rd_wen, inst_ebreak, invalid_inst, halted;

  logic [63:0] regs [32];
  assign rs1_data = regs[rs1_addr];
  assign rs2_data = regs[rs2_addr];

  always #5 clk = ~clk;

  ysyx_22040237_idu #(.XLEN(64), .EBREAK_INST(32'h00100073)) dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_ready(if_ready), .if_inst(if_inst), .if_pc(if_pc),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .inst_opcode(inst_opcode),
    .op1(op1), .op2(op2), .op1_jump(op1_jump), .op2_jump(op2_jump),
    .rd_addr(rd_addr), .rd_wen(rd_wen), .inst_ebreak(inst_ebreak),
    .invalid_inst(invalid_inst), .halted(halted)
  );

  int   n_cmp = 0;
  int   n_err = 0;
  dec_t exp_e;
  logic exp_valid, exp_halt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic dec_t reset_val();
    dec_t d;
    d = '0;
    d.opc = NOP;
    return d;
  endfunction

  // Decode straight from the ISA rules using signed arithmetic
  function automatic dec_t ref_decode(input logic [31:0] w, input logic [63:0] pc,
                                      input logic [63:0] a, input logic [63:0] b);
    dec_t   d;
    longint i_imm, u_imm, j_imm;
    bit     ok;
    d     = reset_val();
    ok    = 1'b0;
    i_imm = longint'($signed(w[31:20]));
    u_imm = longint'($signed({w[31:12], 12'b0}));
    j_imm = longint'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
    if (w == 32'h00100073) begin
      d.ebreak = 1'b1;
      return d;
    end
    case (w[6:0])
      7'h13: if (w[14:12] == 3'd0) begin ok = 1; d.op1 = a; d.op2 = i_imm; end
      7'h33: if (w[14:12] == 3'd0 && w[31:25] == 7'd0) begin ok = 1; d.op1 = a; d.op2 = b; end
      7'h37: begin ok = 1; d.op2 = u_imm; end
      7'h17: begin ok = 1; d.op1 = pc; d.op2 = u_imm; end
      7'h6F: begin ok = 1; d.op1 = pc; d.op2 = 4; d.j1 = pc; d.j2 = -j_imm; end
      7'h67: if (w[14:12] == 3'd0) begin ok = 1; d.op1 = pc; d.op2 = 4; d.j1 = a; d.j2 = -i_imm; end
      default: ok = 0;
    endcase
    if (!ok) begin
      d = reset_val();
      d.invalid = 1'b1;
    end else begin
      d.opc = ADD;
      d.rd  = w[11:7];
      d.wen = (w[11:7] != 5'd0);
    end
    return d;
  endfunction

  function automatic logic [31:0] rand_legal();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 5))
      0:       return {r[31:20], r[19:15], 3'b000, r[11:7], 7'b0010011};
      1:       return {7'd0, r[24:20], r[19:15], 3'b000, r[11:7], 7'b0110011};
      2:       return {r[31:12], r[11:7], 7'b0110111};
      3:       return {r[31:12], r[11:7], 7'b0010111};
      4:       return {r[31:12], r[11:7], 7'b1101111};
      default: return {r[31:20], r[19:15], 3'b000, r[11:7], 7'b1100111};
    endcase
  endfunction

  // One clock: check handshake before the edge, advance model, check outputs after
  task automatic step();
    logic exp_ready, acc;
    @(negedge clk);
    exp_ready = !exp_halt && (!exp_valid || ex_ready);
    acc       = if_valid && exp_ready;
    chk("if_ready", if_ready, exp_ready);
    chk("rs_addr", {rs1_addr, rs2_addr}, {if_inst[19:15], if_inst[24:20]});
    @(posedge clk);
    if (!rst) begin
      exp_valid = 1'b0;
      exp_halt  = 1'b0;
      exp_e     = reset_val();
    end else if (acc) begin
      exp_e     = ref_decode(if_inst, if_pc, regs[if_inst[19:15]], regs[if_inst[24:20]]);
      exp_valid = 1'b1;
      if (exp_e.ebreak || exp_e.invalid) exp_halt = 1'b1;
    end else if (exp_valid && ex_ready) begin
      exp_valid = 1'b0;
    end
    #1;
    chk("ex_valid", ex_valid, exp_valid);
    chk("opcode", inst_opcode, exp_e.opc);
    chk("op1", op1, exp_e.op1);
    chk("op2", op2, exp_e.op2);
    chk("op1_jump", op1_jump, exp_e.j1);
    chk("op2_jump", op2_jump, exp_e.j2);
    chk("rd_wen", rd_wen, exp_e.wen);
    if (!(exp_e.ebreak || exp_e.invalid)) chk("rd_addr", rd_addr, exp_e.rd);
    chk("inst_ebreak", inst_ebreak, exp_e.ebreak && exp_valid);
    chk("invalid_inst", invalid_inst, exp_e.invalid && exp_valid);
    chk("halted", halted, exp_halt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int          eb_cnt, rdy_cnt;
    logic [31:0] bad [4];
    bad[0] = 32'h40208033;  // SUB
    bad[1] = 32'h00109093;  // SLLI
    bad[2] = 32'h000090E7;  // JALR funct3=1
    bad[3] = 32'h00000000;

    for (int i = 0; i < 32; i++) regs[i] = {$urandom, $urandom};
    regs[0]   = 64'd0;
    exp_valid = 1'b0;
    exp_halt  = 1'b0;
    exp_e     = reset_val();
    rst = 1'b0; if_valid = 1'b0; if_inst = 32'h0; if_pc = 64'h0; ex_ready = 1'b1;
    step();
    step();
    rst = 1'b1;

    // ADDI x1,x0,5
    if_valid = 1'b1; if_inst = 32'h00500093; if_pc = 64'h8000_0000;
    step();
    chk("addi_op2", op2, 64'd5);
    chk("addi_rd", rd_addr, 5'd1);
    chk("addi_opc", inst_opcode, ADD);

    // JAL x1,+8
    if_inst = 32'h008000EF;
    step();
    chk("jal_op2_jump", op2_jump, 64'hFFFF_FFFF_FFFF_FFF8);
    chk("jal_target", op1_jump - op2_jump, 64'h8000_0008);

    // Back-pressure, then no-bubble reload
    if_inst = {7'd0, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011};
    ex_ready = 1'b0;
    repeat (3) step();
    chk("bp_hold_op1", op1, 64'h8000_0000);
    ex_ready = 1'b1;
    step();
    chk("bp_reload_op1", op1, regs[1]);

    // Randomized traffic of decodable instructions
    repeat (400) begin
      if_valid = ($urandom_range(0, 3) != 0);
      ex_ready = ($urandom_range(0, 3) != 0);
      if_inst  = rand_legal();
      if_pc    = {$urandom, $urandom};
      step();
    end

    // EBREAK then keep offering work
    ex_ready = 1'b1; if_valid = 1'b1; if_inst = 32'h00100073;
    step();
    eb_cnt = int'(inst_ebreak);
    rdy_cnt = 0;
    repeat (12) begin
      if_inst = rand_legal();
      step();
      eb_cnt  += int'(inst_ebreak);
      rdy_cnt += int'(if_ready);
    end
    chk("ebreak_pulses", eb_cnt, 1);
    chk("halt_ready_cycles", rdy_cnt, 0);

    // All-ones word
    rst = 1'b0; step(); rst = 1'b1;
    if_inst = 32'hFFFF_FFFF;
    step();
    chk("ones_invalid", invalid_inst, 1'b1);
    chk("ones_halted", halted, 1'b1);
    step();

    // Near-miss encodings after some legal traffic
    for (int k = 0; k < 4; k++) begin
      rst = 1'b0; step(); rst = 1'b1;
      repeat (5) begin
        if_valid = ($urandom_range(0, 1) != 0);
        ex_ready = ($urandom_range(0, 1) != 0);
        if_inst  = rand_legal();
        step();
      end
      if_valid = 1'b1; ex_ready = 1'b1; if_inst = bad[k];
      repeat (3) step();
    end

    // ADDI x0,x0,1 then reset while stalled
    rst = 1'b0; step(); rst = 1'b1;
    if_valid = 1'b1; ex_ready = 1'b1; if_inst = 32'h00100013;
    step();
    chk("x0_rd_wen", rd_wen, 1'b0);
    ex_ready = 1'b0;
    step();
    rst = 1'b0;
    step();
    chk("rst_ex_valid", ex_valid, 1'b0);
    chk("rst_halted", halted, 1'b0);
    rst = 1'b1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ysyx_22040237_idu.md
Name: ysyx_22040237_idu

Overview:
- Decode stage feeding ysyx_22040237_exu; produces its opcode, operand, ebreak and invalid-instruction inputs.
- Accepts fetched instructions over a valid/ready handshake.
- Reads the register file through external combinational read ports.
- Holds decoded results in a single-entry output register with a valid/ready handshake toward the EXU.
- Halts intake permanently after issuing EBREAK or an invalid instruction.

Parameters:
- XLEN, 64, datapath width of PC and operands.
- EBREAK_INST, 32'h00100073, encoding that raises inst_ebreak.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- if_valid  in  1  fetched instruction valid
- if_ready  out  1  IDU can accept
- if_inst  in  32  instruction word
- if_pc  in  XLEN  PC of if_inst
- rs1_addr  out  5  regfile read address 1 (combinational from if_inst[19:15])
- rs2_addr  out  5  regfile read address 2 (combinational from if_inst[24:20])
- rs1_data  in  XLEN  regfile read data 1, same cycle
- rs2_data  in  XLEN  regfile read data 2, same cycle
- ex_valid  out  1  output register holds an instruction
- ex_ready  in  1  EXU consumes this cycle
- inst_opcode  out  8  internal opcode (package constants)
- op1, op2  out  XLEN  ALU operands (EXU computes rd_data = op1 + op2)
- op1_jump, op2_jump  out  XLEN  jump operands (EXU computes target = op1_jump - op2_jump)
- rd_addr  out  5  destination register
- rd_wen  out  1  destination write enable
- inst_ebreak  out  1  EBREAK issued
- invalid_inst  out  1  undecodable instruction issued
- halted  out  1  IDU in HALT state

Behaviour:
- Reset (rst==0 at posedge):
  - ex_valid, rd_wen, inst_ebreak, invalid_inst and halted go to 0.
  - inst_opcode = INST_NOP; all data outputs = 0.
  - State = RUN.
- Reset dominates all other events, including a mid-handshake transfer; no partial state survives.
- States:
  - RUN: intake enabled.
  - HALT: intake disabled. Exit only via reset.
- if_ready = (state==RUN) && (!ex_valid || ex_ready). This is combinational; full throughput allows one instruction per cycle.
- Accept = if_valid && if_ready. On accept, all outputs load with the decode of if_inst/if_pc/rs*_data and ex_valid<=1. Latency is 1 cycle.
- ex_valid && ex_ready && !accept → ex_valid<=0. Outputs keep their last values while ex_valid==0.
- While ex_valid && !ex_ready, all outputs are held stable.
- Decode (all valid instructions: inst_opcode = INST_ADD, rd_addr = inst[11:7], rd_wen = (rd_addr!=0)):
  - ADDI (opc 0010011, f3 000): op1=rs1_data, op2=sext(I-imm).
  - ADD (opc 0110011, f3 000, f7 0): op1=rs1_data, op2=rs2_data.
  - LUI: op1=0, op2=sext(U-imm<<12).
  - AUIPC: op1=if_pc, op2=sext(U-imm<<12).
  - JAL: op1=if_pc, op2=4, op1_jump=if_pc, op2_jump=-sext(J-imm).
  - JALR (f3 000): op1=if_pc, op2=4, op1_jump=rs1_data, op2_jump=-sext(I-imm). Clearing target bit 0 is the IFU's job.
  - Non-jump instructions: op1_jump = op2_jump = 0.
- EBREAK (if_inst==EBREAK_INST): inst_opcode=INST_NOP, inst_ebreak=1, rd_wen=0.
- Any other word: inst_opcode=INST_NOP, invalid_inst=1, rd_wen=0, all operands 0.
- On accepting EBREAK or an invalid instruction, state<=HALT and halted<=1 in the same edge. The issued entry still drains normally to the EXU.
- inst_ebreak/invalid_inst are qualified by ex_valid. Once the entry is consumed they clear, so the EXU's per-clock DPI call fires exactly once.
- All arithmetic is XLEN-wide two's complement; sign extension is from the immediate MSB. Negation wraps modulo 2^XLEN.

Decomposition:
- Shared define/package file holds:
  - ysyx_22040237_INST_NOP=8'h00 and ysyx_22040237_INST_ADD=8'h01.
  - RISC-V major opcode constants.
  - RUN/HALT state encoding.
  - EBREAK encoding.
- Sub-module ysyx_22040237_imm_gen: combinational I/U/J immediate extraction and sign extension, selected by major opcode.

Test Plan:
- Reset, then ADDI x1,x0,5 (32'h00500093), rs1_data=0, ex_ready=1 → next cycle: ex_valid=1, INST_ADD, op1=0, op2=5, rd_addr=1, rd_wen=1.
- JAL x1,+8 at pc 64'h8000_0000 → op1=64'h8000_0000, op2=4, op1_jump=64'h8000_0000, op2_jump=64'hFFFF_FFFF_FFFF_FFF8; EXU target = 64'h8000_0008.
- Back-pressure: ex_ready=0 for 3 cycles with if_valid=1 → if_ready=0, outputs held constant. When ex_ready=1, the next instruction loads on the same edge with no bubble.
- EBREAK then further valid words → inst_ebreak=1 with ex_valid for one transfer, halted=1, if_ready stays 0 for ≥10 cycles.
- Word 32'hFFFF_FFFF → invalid_inst=1, rd_wen=0, halted=1.
- ADDI x0,x0,1 → rd_wen=0. Then assert rst=0 while ex_valid=1 and ex_ready=0 → ex_valid=0 and state RUN after the edge.
